// File: rtl/bounding_box_scan.sv
// Bounding-box scanner: walks an interleaved-channel frame buffer one sample
// at a time over a req/ready/valid read port and reports the box, count and
// found flag of all foreground pixels.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// LOAD   | check geometry, compute row stride, clear working registers
// REQ    | read request presented, waiting for rd_ready
// WAIT   | one read outstanding, waiting for rd_valid
// EVAL   | classify completed pixel, advance x/y
// DONE   | results valid, waiting for the next start
module bounding_box_scan #(
    parameter int COORD_W   = 11,
    parameter int MAX_W     = 2047,
    parameter int MAX_H     = 2047,
    parameter int CHANNELS  = 3,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 32,
    parameter int ROW_ALIGN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic [COORD_W-1:0]   img_w,
    input  logic [COORD_W-1:0]   img_h,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [DATA_W-1:0]    threshold,
    input  logic [1:0]           mode,
    output logic                 rd_req,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic                 rd_ready,
    input  logic                 rd_valid,
    input  logic [DATA_W-1:0]    rd_data,
    output logic [COORD_W-1:0]   x_min,
    output logic [COORD_W-1:0]   x_max,
    output logic [COORD_W-1:0]   y_min,
    output logic [COORD_W-1:0]   y_max,
    output logic                 found,
    output logic [2*COORD_W-1:0] pix_count
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_EVAL, S_DONE} state_t;

    localparam int SUM_W = DATA_W + 2;
    localparam int THR_W = DATA_W + 3;
    localparam int CNT_W = 2 * COORD_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(ROW_ALIGN - 1);
    localparam logic [1:0]        C_LAST     = 2'(CHANNELS - 1);

    state_t state, state_nxt;

    logic [COORD_W-1:0] w_r, h_r, x_r, y_r;
    logic [ADDR_W-1:0]  base_r, stride_r;
    logic [DATA_W-1:0]  thr_r;
    logic [1:0]         mode_r, c_r;
    logic               any_f, all_f;
    logic [SUM_W-1:0]   sum_r;
    logic [COORD_W-1:0] xmin_w, xmax_w, ymin_w, ymax_w;
    logic [CNT_W-1:0]   cnt_w;

    logic               geom_bad, last_pix, row_end, fg, lt;
    logic [THR_W-1:0]   thr_x;
    logic [COORD_W-1:0] xmin_n, xmax_n, ymin_n, ymax_n;
    logic [CNT_W-1:0]   cnt_n;

    // Classification, box update and geometry decode for the current pixel
    always_comb begin
        geom_bad = (w_r == '0) || (h_r == '0) ||
                   (32'(w_r) > MAX_W) || (32'(h_r) > MAX_H);
        row_end  = (x_r == w_r - 1'b1);
        last_pix = row_end && (y_r == h_r - 1'b1);
        lt       = (rd_data < thr_r);
        thr_x    = THR_W'(thr_r) * THR_W'(CHANNELS);
        case (mode_r)
            2'd1:    fg = all_f;
            2'd2:    fg = (THR_W'(sum_r) < thr_x);
            default: fg = any_f;
        endcase
        xmin_n = (fg && x_r < xmin_w) ? x_r : xmin_w;
        xmax_n = (fg && x_r > xmax_w) ? x_r : xmax_w;
        ymin_n = (fg && y_r < ymin_w) ? y_r : ymin_w;
        ymax_n = (fg && y_r > ymax_w) ? y_r : ymax_w;
        cnt_n  = cnt_w + CNT_W'(fg);
        rd_addr = '0;
        if (state == S_REQ)
            rd_addr = base_r + ADDR_W'(y_r) * stride_r
                    + ADDR_W'(x_r) * ADDR_W'(CHANNELS) + ADDR_W'(c_r);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake/status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_req    = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                busy      = 1'b1;
                state_nxt = geom_bad ? S_DONE : S_REQ;
            end
            S_REQ: begin
                busy   = 1'b1;
                rd_req = 1'b1;
                if (rd_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (rd_valid) state_nxt = (c_r == C_LAST) ? S_EVAL : S_REQ;
            end
            S_EVAL: begin
                busy      = 1'b1;
                state_nxt = last_pix ? S_DONE : S_REQ;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nxt = S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: input capture, sample accumulation, scan position and results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_r <= '0; h_r <= '0; base_r <= '0; thr_r <= '0; mode_r <= '0;
            stride_r <= '0; x_r <= '0; y_r <= '0; c_r <= '0;
            any_f <= 1'b0; all_f <= 1'b1; sum_r <= '0;
            xmin_w <= '1; ymin_w <= '1; xmax_w <= '0; ymax_w <= '0; cnt_w <= '0;
            err <= 1'b0; found <= 1'b0; pix_count <= '0;
            x_min <= '0; x_max <= '0; y_min <= '0; y_max <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_r    <= img_w;
                        h_r    <= img_h;
                        base_r <= base_addr;
                        thr_r  <= threshold;
                        mode_r <= mode;
                    end
                end
                S_LOAD: begin
                    stride_r <= (ADDR_W'(w_r) * ADDR_W'(CHANNELS) + ALIGN_MASK) & ~ALIGN_MASK;
                    x_r <= '0; y_r <= '0; c_r <= '0;
                    any_f <= 1'b0; all_f <= 1'b1; sum_r <= '0;
                    xmin_w <= '1; ymin_w <= '1; xmax_w <= '0; ymax_w <= '0; cnt_w <= '0;
                    err <= geom_bad;
                    if (geom_bad) begin
                        found <= 1'b0; pix_count <= '0;
                        x_min <= '0; x_max <= '0; y_min <= '0; y_max <= '0;
                    end
                end
                S_WAIT: begin
                    if (rd_valid) begin
                        any_f <= any_f | lt;
                        all_f <= all_f & lt;
                        sum_r <= sum_r + SUM_W'(rd_data);
                        if (c_r != C_LAST) c_r <= c_r + 1'b1;
                    end
                end
                S_EVAL: begin
                    xmin_w <= xmin_n; xmax_w <= xmax_n;
                    ymin_w <= ymin_n; ymax_w <= ymax_n;
                    cnt_w  <= cnt_n;
                    any_f <= 1'b0; all_f <= 1'b1; sum_r <= '0; c_r <= '0;
                    if (last_pix) begin
                        // An empty frame reports zeros rather than the min/max sentinels
                        found     <= (cnt_n != '0);
                        pix_count <= cnt_n;
                        x_min <= (cnt_n != '0) ? xmin_n : '0;
                        x_max <= (cnt_n != '0) ? xmax_n : '0;
                        y_min <= (cnt_n != '0) ? ymin_n : '0;
                        y_max <= (cnt_n != '0) ? ymax_n : '0;
                    end else if (row_end) begin
                        x_r <= '0;
                        y_r <= y_r + 1'b1;
                    end else begin
                        x_r <= x_r + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
